// File: rtl/vbus_if.sv
// vbus_if: system-bus signal bundle between an initiator (master) and
// the memory target (slave). Request/write-data flow master->slave;
// acknowledge and read-response flow slave->master.
interface vbus_if;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic        ackout;
    logic [1:0]  reqout;
    logic [3:0]  reqtar;
    logic [1:0]  lenout;
    logic [2:0]  cmdout;
    logic [31:0] addrdataout;

    modport master (
        output selin, cmdin, lenin, addrdatain, ackin,
        input  ackout, reqout, reqtar, lenout, cmdout, addrdataout
    );

    modport slave (
        input  selin, cmdin, lenin, addrdatain, ackin,
        output ackout, reqout, reqtar, lenout, cmdout, addrdataout
    );
endinterface

// File: rtl/vbus_mem_target.sv
// vbus_mem_target: bus target holding a 2**AW x 32 word RAM.
// Accepts READ/WRITE bursts of 1<<len beats, absorbs write beats and
// returns read data by requesting the bus back toward the initiator.
// Optional macro VBUS_TGT_ERR_EN: illegal commands seen in IDLE are
// acked and answered with one ERR beat carrying the offending address.
module vbus_mem_target #(
    parameter int          AW       = 10,
    parameter logic [3:0]  RESP_TAR = 4'h1,
    parameter logic [1:0]  RESP_PRI = 2'b01
) (
    input  logic  clk,
    input  logic  reset,
    vbus_if.slave bus
);
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;
    localparam logic [2:0] CMD_RDATA = 3'b011;
    localparam logic [2:0] CMD_ERR   = 3'b111;

    typedef enum logic [1:0] {IDLE, WR_DATA, RD_REQ, RD_DATA} state_t;

    state_t        state;
    logic [31:0]   ram [2**AW];
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic [1:0]    len;
    logic [2:0]    cnt;
    logic [2:0]    last_beat;
    logic          err;
    logic [31:0]   req_addr;
    logic          wr_beat;
    logic          accept_err;
    logic          accept;

    // Index wraps naturally at 2**AW because it is exactly AW bits wide.
    assign idx_nxt   = idx + AW'(1);
    assign last_beat = 3'((4'd1 << len) - 4'd1);
    assign wr_beat   = reset && (state == WR_DATA) && bus.selin && (bus.cmdin == CMD_WRITE);

`ifdef VBUS_TGT_ERR_EN
    assign accept_err = bus.cmdin > CMD_WRITE;
`else
    assign accept_err = 1'b0;
`endif

    assign accept = bus.selin &&
                    ((bus.cmdin == CMD_READ) || (bus.cmdin == CMD_WRITE) || accept_err);

    // RAM write port; kept out of the reset block so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_beat) ram[idx] <= bus.addrdatain;
    end

    // Request/response FSM with registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            bus.ackout      <= 1'b0;
            bus.reqout      <= '0;
            bus.reqtar      <= '0;
            bus.lenout      <= '0;
            bus.cmdout      <= '0;
            bus.addrdataout <= '0;
            idx             <= '0;
            len             <= '0;
            cnt             <= '0;
            err             <= 1'b0;
            req_addr        <= '0;
        end else begin
            bus.ackout <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        bus.ackout <= 1'b1;
                        req_addr   <= bus.addrdatain;
                        idx        <= bus.addrdatain[AW+1:2];
                        len        <= accept_err ? 2'd0 : bus.lenin;
                        err        <= accept_err;
                        state      <= (bus.cmdin == CMD_WRITE) ? WR_DATA : RD_REQ;
                    end
                end
                WR_DATA: begin
                    if (wr_beat) begin
                        idx <= idx_nxt;
                        cnt <= cnt + 3'd1;
                        if (cnt == last_beat) state <= IDLE;
                    end
                end
                RD_REQ: begin
                    bus.reqout <= RESP_PRI;
                    bus.reqtar <= RESP_TAR;
                    bus.lenout <= len;
                    // Grant only counts once our request is actually visible.
                    if ((bus.reqout != 2'b00) && bus.ackin) begin
                        state           <= RD_DATA;
                        bus.cmdout      <= err ? CMD_ERR : CMD_RDATA;
                        bus.addrdataout <= err ? req_addr : ram[idx];
                    end
                end
                RD_DATA: begin
                    if (bus.ackin) begin
                        if (cnt == last_beat) begin
                            state           <= IDLE;
                            bus.reqout      <= '0;
                            bus.reqtar      <= '0;
                            bus.lenout      <= '0;
                            bus.cmdout      <= '0;
                            bus.addrdataout <= '0;
                        end else begin
                            cnt             <= cnt + 3'd1;
                            idx             <= idx_nxt;
                            bus.addrdataout <= ram[idx_nxt];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vbus_mem_target.md
Name: vbus_mem_target

Overview:
- Bus responder (target) for the video-controller system bus. It serves the frame-fetch read bursts and write bursts issued by bus initiators such as the video controller.
- Holds a word-addressed frame/line buffer RAM. Acknowledges request cycles, absorbs write beats, and returns read data by requesting the bus back toward the initiator.
- Sits between the bus arbiter and on-chip pixel memory.

Parameters:
- AW, 10, RAM word-address width; depth = 2**AW 32-bit words
- RESP_TAR, 4'h1, reqtar value driven on read responses (initiator id of the video controller)
- RESP_PRI, 2'b01, reqout level asserted when requesting the bus for response

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- selin  in  1  arbiter has selected this target for the current bus cycle
- cmdin  in  3  000 IDLE, 001 READ, 010 WRITE; 011-111 illegal
- lenin  in  2  burst length code: beats = 1<<lenin (1,2,4,8)
- addrdatain  in  32  byte address on request cycle; write data on write beats
- ackin  in  1  grant on response request; per-beat accept on read data
- ackout  out  1  one-cycle acknowledge of an accepted request cycle
- reqout  out  2  bus request level for the read response; 0 = none
- reqtar  out  4  response destination id
- lenout  out  2  echo of latched lenin on the response
- cmdout  out  3  011 RDATA during read data beats (111 ERR with option); else 000
- addrdataout  out  32  read data beat

Behaviour:
- Reset (reset==0 at posedge): state IDLE. ackout, reqout, reqtar, lenout, cmdout, addrdataout and the beat counter all go to 0. RAM contents are preserved. Reset asserted mid-burst aborts the burst and sends no further beats.
- Word index = addr[AW+1:2]. addr[1:0] is ignored. The index increments by 1 per beat and wraps modulo 2**AW (index 2**AW-1 is followed by 0).
- FSM states:
  - IDLE
    - selin & READ: latch addr and len, ackout=1 next cycle, go to RD_REQ.
    - selin & WRITE: latch, ackout=1, go to WR_DATA.
    - IDLE cmd or illegal cmd: ignored, no ack.
  - WR_DATA
    - Each cycle with selin=1 and cmdin=WRITE is one beat: RAM[idx] <= addrdatain, idx++, count++.
    - Cycles without that combination are stalls.
    - After beat (1<<len) go to IDLE. A write to word N is readable by any later request.
  - RD_REQ
    - Drive reqout=RESP_PRI, reqtar=RESP_TAR, lenout=len. Hold until ackin=1, then go to RD_DATA.
    - RAM prefetch of the first word happens here.
  - RD_DATA
    - Every cycle: cmdout=RDATA, addrdataout=RAM[idx]. reqout stays asserted.
    - ackin=1 consumes the beat; idx++ and the next word is presented on the following cycle. ackin=0 holds the same beat stable.
    - After the last beat is accepted, the next cycle goes to IDLE with reqout, cmdout and addrdataout = 0.
- Busy rule: selin while not IDLE gets no ackout. The initiator retries.
- Throughput: 1 beat/cycle with ackin held high.
- Latency: request cycle to ackout = 1 cycle; ackout to reqout = 1 cycle.
- No request is accepted in the same cycle the FSM returns to IDLE. Acceptance resumes the following cycle.

Optional Feature:
- Macro: VBUS_TGT_ERR_EN.
- Defined: selin with an illegal cmd in IDLE is acked. The block then goes to RD_REQ and returns a single beat with cmdout=111 ERR, lenout=0, addrdataout = offending address.
- Undefined: illegal commands are silently ignored, with no ack and no response.

Test Plan:
- Reset: drive reset=0 for 2 cycles mid read burst -> all outputs 0 next cycle; prior RAM writes still readable afterwards.
- Write 4-beat: WRITE, addr 0x100, len=2, beats 0xA0..0xA3 -> ackout one pulse; RAM words 0x40..0x43 hold 0xA0..0xA3.
- Read 4-beat with ackin high: READ 0x100, len=2 -> reqout=01, reqtar=1, lenout=2; after grant, RDATA beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then idle.
- Read stall: same read with ackin low for 3 cycles after beat 1 -> beat 1 (0xA1) held stable; no beat lost or duplicated.
- Wrap: AW=10, write 2 beats at 0xFFC (idx 1023) -> second beat lands at idx 0; a read of 0x000 returns it.
- Busy/illegal: selin READ during RD_DATA -> no ackout. cmd 101 in IDLE -> no ack without the macro; with VBUS_TGT_ERR_EN, ack and one ERR beat carrying the address.
